// File: rtl/axi3_wr_arbiter_pkg.sv
// AXI3 write-channel bundles shared by the write sources, the arbiter and the crossbar port,
// plus the arbiter's transaction-phase encoding.
package axi3_wr_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // Master-driven AW/W fields plus bready
  typedef struct packed {
    logic                  awvalid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_LEN_W-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  bready;
  } axi3_wr_req_t;

  // Slave-driven readies and the B channel
  typedef struct packed {
    logic                awready;
    logic                wready;
    logic                bvalid;
    logic [1:0]          bresp;
    logic [AXI_ID_W-1:0] bid;
  } axi3_wr_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AW   = 2'd1,
    ARB_W    = 2'd2,
    ARB_B    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/axi3_wr_arbiter_rr_pick.sv
// Round-robin selector: one-hot of the first set request at or after ptr, wrapping to index 0.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pool;

  // Prefer requests at/above ptr; fall back to the full set to wrap. Isolate lowest set bit.
  always_comb begin
    hi_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    masked  = req & hi_mask;
    pool    = (|masked) ? masked : req;
    gnt     = pool & (~pool + NUM_REQ'(1));
  end

endmodule

// File: rtl/axi3_wr_arbiter.sv
// Whole-transaction round-robin arbiter sharing one AXI3 write port; one transaction in flight,
// so W and B follow the registered grant.
module axi3_wr_arbiter
  import axi3_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  axi3_wr_req_t  [NUM_REQ-1:0]         s_req,
  input  logic          [NUM_REQ-1:0][ID_WIDTH-1:0] s_awid,
  input  logic          [NUM_REQ-1:0][ID_WIDTH-1:0] s_wid,
  output axi3_wr_resp_t [NUM_REQ-1:0]         s_resp,
  output axi3_wr_req_t                        m_req,
  output logic          [ID_WIDTH-1:0]        m_awid,
  output logic          [ID_WIDTH-1:0]        m_wid,
  input  axi3_wr_resp_t                       m_resp,
  output logic          [NUM_REQ-1:0]         grant,
  output logic                                protocol_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [PTR_W-1:0]     gidx, gidx_d;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_d;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 err_d;

  logic [NUM_REQ-1:0]   aw_req;
  logic [NUM_REQ-1:0]   pick;
  logic [PTR_W-1:0]     pick_idx;
  axi3_wr_req_t         sel;
  logic                 aw_hs, w_hs, b_hs;

  always_comb begin
    aw_req = '0;
    for (int i = 0; i < NUM_REQ; i++) aw_req[i] = s_req[i].awvalid;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (aw_req),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PTR_W'(i);
  end

  // gidx is registered alongside the one-hot grant so the data muxes need no encoder
  assign sel   = s_req[gidx];
  assign aw_hs = sel.awvalid & m_resp.awready;
  assign w_hs  = sel.wvalid & m_resp.wready;
  assign b_hs  = m_resp.bvalid & sel.bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      gidx         <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      len_q        <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_d;
      grant        <= grant_d;
      gidx         <= gidx_d;
      rr_ptr       <= rr_ptr_d;
      beat_cnt     <= beat_cnt_d;
      len_q        <= len_d;
      protocol_err <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    gidx_d     = gidx;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    len_d      = len_q;
    err_d      = protocol_err;
    unique case (state)
      ARB_IDLE: begin
        if (|aw_req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ARB_AW;
        end
      end
      ARB_AW: begin
        if (aw_hs) begin
          len_d      = LEN_WIDTH'(sel.awlen);
          beat_cnt_d = '0;
          state_d    = ARB_W;
        end
      end
      ARB_W: begin
        if (w_hs) begin
          if (beat_cnt != '1) beat_cnt_d = beat_cnt + LEN_WIDTH'(1);
          // wlast is trusted for sequencing; a mismatch with awlen is only flagged
          if (sel.wlast != (beat_cnt == len_q)) err_d = 1'b1;
          if (sel.wlast) state_d = ARB_B;
        end
      end
      ARB_B: begin
        if (b_hs) begin
          rr_ptr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_req  = '0;
    m_awid = '0;
    m_wid  = '0;
    s_resp = '0;
    unique case (state)
      ARB_AW: begin
        m_req.awvalid         = sel.awvalid;
        m_req.awaddr          = sel.awaddr;
        m_req.awlen           = sel.awlen;
        m_req.awsize          = sel.awsize;
        m_req.awburst         = sel.awburst;
        m_awid                = s_awid[gidx];
        s_resp[gidx].awready  = m_resp.awready;
      end
      ARB_W: begin
        m_req.wvalid          = sel.wvalid;
        m_req.wdata           = sel.wdata;
        m_req.wstrb           = sel.wstrb;
        m_req.wlast           = sel.wlast;
        m_wid                 = s_wid[gidx];
        s_resp[gidx].wready   = m_resp.wready;
      end
      ARB_B: begin
        m_req.bready          = sel.bready;
        s_resp[gidx].bvalid   = m_resp.bvalid;
        s_resp[gidx].bresp    = m_resp.bresp;
        s_resp[gidx].bid      = m_resp.bid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Bench for axi3_wr_arbiter: directed requester/slave stimulus, a transaction-level model
// checked every cycle, and literal expectations on order, beat counts and the error flag.
module tb_axi3_wr_arbiter;
  import axi3_wr_arbiter_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  axi3_wr_req_t  [N-1:0]      s_req;
  logic          [N-1:0][3:0] s_awid, s_wid;
  axi3_wr_resp_t [N-1:0]      s_resp;
  axi3_wr_req_t               m_req;
  logic          [3:0]        m_awid, m_wid;
  axi3_wr_resp_t              m_resp;
  logic          [N-1:0]      grant;
  logic                       protocol_err;

  int compared = 0, mismatched = 0;
  int busy = 0, nbeats = 0, nstall = 0;
  bit wtoggle = 1'b0;

  // model: phase 0 idle, 1 address, 2 data, 3 response
  int ph = 0, own = 0, ptr = 0, beats = 0, mlen = 0;
  bit merr = 1'b0;
  int served[$];

  always #5 clk = ~clk;

  axi3_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(4), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .s_req(s_req), .s_awid(s_awid), .s_wid(s_wid), .s_resp(s_resp),
    .m_req(m_req), .m_awid(m_awid), .m_wid(m_wid), .m_resp(m_resp), .grant(grant),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; own = 0; ptr = 0; beats = 0; mlen = 0; merr = 1'b0;
    end else begin
      case (ph)
        0: for (int k = 0; k < N; k++)
             if (ph == 0 && s_req[(ptr + k) % N].awvalid) begin
               own = (ptr + k) % N; ph = 1; served.push_back(own);
             end
        1: if (s_req[own].awvalid && m_resp.awready) begin
             mlen = int'(s_req[own].awlen); beats = 0; ph = 2;
           end
        2: if (s_req[own].wvalid && m_resp.wready) begin
             if (s_req[own].wlast != (beats == mlen)) merr = 1'b1;
             beats = (beats < 15) ? beats + 1 : 15;
             if (s_req[own].wlast) ph = 3;
           end
        3: if (m_resp.bvalid && s_req[own].bready) begin
             ptr = (own + 1) % N; ph = 0;
           end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    bit ea, ew;
    eg = (ph == 0) ? '0 : N'(1) << own;
    ea = (ph == 1) && s_req[own].awvalid;
    ew = (ph == 2) && s_req[own].wvalid;
    chk("grant", 64'(grant), 64'(eg));
    chk("m_awvalid", 64'(m_req.awvalid), 64'(ea));
    if (ea) begin
      chk("m_awaddr", 64'(m_req.awaddr), 64'(s_req[own].awaddr));
      chk("m_awlen", 64'(m_req.awlen), 64'(s_req[own].awlen));
      chk("m_awid", 64'(m_awid), 64'(s_awid[own]));
    end
    chk("m_wvalid", 64'(m_req.wvalid), 64'(ew));
    if (ew) begin
      chk("m_wdata", 64'(m_req.wdata), 64'(s_req[own].wdata));
      chk("m_wlast", 64'(m_req.wlast), 64'(s_req[own].wlast));
      chk("m_wid", 64'(m_wid), 64'(s_wid[own]));
    end
    chk("m_bready", 64'(m_req.bready), 64'((ph == 3) && s_req[own].bready));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("awready%0d", k), 64'(s_resp[k].awready), 64'((ph == 1) && k == own && m_resp.awready));
      chk($sformatf("wready%0d", k), 64'(s_resp[k].wready), 64'((ph == 2) && k == own && m_resp.wready));
      chk($sformatf("bvalid%0d", k), 64'(s_resp[k].bvalid), 64'((ph == 3) && k == own && m_resp.bvalid));
      if ((ph == 3) && k == own && m_resp.bvalid)
        chk($sformatf("bid%0d", k), 64'(s_resp[k].bid), 64'(m_resp.bid));
    end
    chk("protocol_err", 64'(protocol_err), 64'(merr));
    if (m_req.wvalid && m_resp.wready) nbeats++;
    if (ph == 3 && m_resp.bvalid && !m_req.bready) nstall++;
  end

  // downstream slave: awready high, wready steady or toggling, B one cycle after the last beat
  initial forever begin : slv
    bit lhs, bhs;
    logic [3:0] lid;
    @(negedge clk);
    lhs = m_req.wvalid && m_resp.wready && m_req.wlast;
    bhs = m_resp.bvalid && m_req.bready;
    lid = m_wid;
    @(posedge clk); #1;
    if (rst) m_resp.bvalid = 1'b0;
    else begin
      if (bhs) m_resp.bvalid = 1'b0;
      if (lhs) begin m_resp.bvalid = 1'b1; m_resp.bresp = lid[1:0]; m_resp.bid = lid; end
    end
    m_resp.wready = wtoggle ? ~m_resp.wready : 1'b1;
  end

  task automatic req_txn(input int i, input int len, input int lastb, input int bdelay);
    bit ab, hs;
    int cnt, st;
    ab = 1'b0;
    @(posedge clk); #1;
    s_awid[i]          = 4'(i * 5 + len);
    s_req[i].awvalid   = 1'b1;
    s_req[i].awaddr    = 32'(32'h1000 * (i + 1) + len);
    s_req[i].awlen     = 4'(len);
    s_req[i].awsize    = 3'd2;
    s_req[i].awburst   = 2'b01;
    hs = 1'b0; cnt = 0;
    while (!hs && !ab) begin
      @(negedge clk);
      hs = s_resp[i].awready; ab = rst; cnt++;
      if (cnt > 300) begin
        compared++; mismatched++; ab = 1'b1;
        $display("FAIL req%0d_aw_timeout: waited %0d cycles, want awready", i, cnt);
      end
      @(posedge clk); #1;
    end
    s_req[i].awvalid = 1'b0;
    for (int b = 0; b <= lastb && !ab; b++) begin
      s_req[i].wvalid = 1'b1;
      s_req[i].wdata  = {8'(i), 8'(b), 16'hbeef};
      s_req[i].wstrb  = 4'hf;
      s_req[i].wlast  = (b == lastb);
      s_wid[i]        = s_awid[i];
      hs = 1'b0; cnt = 0;
      while (!hs && !ab) begin
        @(negedge clk);
        hs = s_resp[i].wready; ab = rst; cnt++;
        if (cnt > 300) begin
          compared++; mismatched++; ab = 1'b1;
          $display("FAIL req%0d_w_timeout: waited %0d cycles, want wready", i, cnt);
        end
        @(posedge clk); #1;
      end
    end
    s_req[i].wvalid = 1'b0;
    s_req[i].wlast  = 1'b0;
    if (!ab) begin
      s_req[i].bready = (bdelay == 0);
      hs = 1'b0; cnt = 0; st = 0;
      while (!hs && !ab) begin
        @(negedge clk);
        hs = s_resp[i].bvalid && s_req[i].bready;
        if (s_resp[i].bvalid && !s_req[i].bready) st++;
        ab = rst; cnt++;
        if (cnt > 300) begin
          compared++; mismatched++; ab = 1'b1;
          $display("FAIL req%0d_b_timeout: waited %0d cycles, want bvalid", i, cnt);
        end
        @(posedge clk); #1;
        if (st >= bdelay) s_req[i].bready = 1'b1;
      end
    end
    s_req[i].bready = 1'b0;
    busy--;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (busy != 0 && c < 3000) begin @(negedge clk); c++; end
    chk({nm, "_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_req = '0; s_awid = '0; s_wid = '0;
    m_resp = '0; m_resp.awready = 1'b1; m_resp.wready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_err", 64'(protocol_err), 64'(0));
    chk("rst_awvalid", 64'(m_req.awvalid), 64'(0));
    chk("rst_awready0", 64'(s_resp[0].awready), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // single 8-beat burst from req0, grant one cycle after awvalid
    served.delete(); nbeats = 0; busy = 1;
    fork req_txn(0, 7, 7, 0); join_none
    @(negedge clk);
    @(negedge clk);
    chk("t1_awvalid_up", 64'(s_req[0].awvalid), 64'(1));
    chk("t1_grant_pre", 64'(grant), 64'(0));
    @(negedge clk);
    chk("t1_grant", 64'(grant), 64'(2'b01));
    wait_done("t1");
    chk("t1_nserved", 64'(served.size()), 64'(1));
    chk("t1_beats", 64'(nbeats), 64'(8));
    chk("t1_err", 64'(protocol_err), 64'(0));

    // simultaneous requests from reset: 0 then 1, twice
    do_reset(); served.delete();
    busy = 2;
    fork req_txn(0, 3, 3, 0); req_txn(1, 1, 1, 0); join_none
    wait_done("t2a");
    busy = 2;
    fork req_txn(0, 3, 3, 0); req_txn(1, 1, 1, 0); join_none
    wait_done("t2b");
    chk("t2_nserved", 64'(served.size()), 64'(4));
    chk("t2_s0", 64'(served[0]), 64'(0));
    chk("t2_s1", 64'(served[1]), 64'(1));
    chk("t2_s2", 64'(served[2]), 64'(0));
    chk("t2_s3", 64'(served[3]), 64'(1));

    // 16-beat burst with toggling wready, req1 single beat arrives mid-burst
    served.delete(); nbeats = 0; wtoggle = 1'b1; busy = 2;
    fork
      req_txn(0, 15, 15, 0);
      begin repeat (3) @(posedge clk); #1; req_txn(1, 0, 0, 0); end
    join_none
    wait_done("t3");
    wtoggle = 1'b0;
    chk("t3_s0", 64'(served[0]), 64'(0));
    chk("t3_s1", 64'(served[1]), 64'(1));
    chk("t3_beats", 64'(nbeats), 64'(17));
    chk("t3_err", 64'(protocol_err), 64'(0));

    // early wlast on beat 3 of an 8-beat burst, then a normal transaction
    served.delete(); busy = 1;
    fork req_txn(0, 7, 2, 0); join_none
    wait_done("t4a");
    chk("t4_err", 64'(protocol_err), 64'(1));
    busy = 1;
    fork req_txn(1, 0, 0, 0); join_none
    wait_done("t4b");
    chk("t4_err_sticky", 64'(protocol_err), 64'(1));
    chk("t4_s1", 64'(served[1]), 64'(1));

    // B held three cycles by requester, then pointer moves past req0
    served.delete(); nstall = 0; busy = 1;
    fork req_txn(0, 3, 3, 3); join_none
    wait_done("t5a");
    chk("t5_stall", 64'(nstall), 64'(3));
    busy = 2;
    fork req_txn(0, 0, 0, 0); req_txn(1, 0, 0, 0); join_none
    wait_done("t5b");
    chk("t5_s1", 64'(served[1]), 64'(1));
    chk("t5_s2", 64'(served[2]), 64'(0));

    // reset in the middle of a data phase
    served.delete(); busy = 1;
    fork req_txn(0, 7, 7, 0); join_none
    begin
      int c;
      c = 0;
      while (!m_req.wvalid && c < 100) begin @(negedge clk); c++; end
    end
    chk("t6_in_w", 64'(m_req.wvalid), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("t6_wvalid", 64'(m_req.wvalid), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    chk("t6_err", 64'(protocol_err), 64'(0));
    wait_done("t6a");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    served.delete(); busy = 1;
    fork req_txn(1, 0, 0, 0); join_none
    wait_done("t6b");
    chk("t6_nserved", 64'(served.size()), 64'(1));
    chk("t6_s0", 64'(served[0]), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi3_wr_arbiter.md
Name: axi3_wr_arbiter

Overview:
- Shares one AXI3 write master port between N write requesters, e.g. the dcache write buffer (8-beat bursts) and the uncached store path (single beats).
- Grants one whole transaction at a time (AW, then all W beats, then B) and rotates priority round-robin.
- Only one write transaction is outstanding downstream at a time, so W and B routing is implicit from the grant.
- Sits between the cache/uncached write sources and the top-level AXI crossbar.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- ID_WIDTH, 4, width of awid/wid/bid.
- LEN_WIDTH, 4, width of awlen (AXI3 burst length field).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- s_req  input  [NUM_REQ-1:0] axi3_wr_req_t  per-requester AW/W/B-ready request bundle.
- s_awid  input  [NUM_REQ-1:0][ID_WIDTH-1:0]  per-requester awid.
- s_wid  input  [NUM_REQ-1:0][ID_WIDTH-1:0]  per-requester wid.
- s_resp  output  [NUM_REQ-1:0] axi3_wr_resp_t  per-requester awready/wready/bvalid/bresp/bid.
- m_req  output  axi3_wr_req_t  to downstream AXI3 write port.
- m_awid  output  ID_WIDTH  downstream awid.
- m_wid  output  ID_WIDTH  downstream wid.
- m_resp  input  axi3_wr_resp_t  from downstream.
- grant  output  NUM_REQ  one-hot current owner; zero in ARB_IDLE.
- protocol_err  output  1  sticky flag: wlast inconsistent with latched awlen.

Behaviour:
- Reset, async: state=ARB_IDLE, grant=0, rr_ptr=0, beat_cnt=0, len_q=0, protocol_err=0. All m_req valids and all s_resp awready/wready/bvalid read 0.
- States:
  - ARB_IDLE: m_req.awvalid/wvalid=0, m_req.bready=0. If any s_req[i].awvalid=1, pick the first requesting index at or after rr_ptr (wrapping), register grant, go ARB_AW. Arbitration costs exactly 1 cycle.
  - ARB_AW: forward the granted requester's AW fields and awid to m_req combinationally. Route m_resp.awready only to the granted s_resp. On awvalid&awready: latch len_q=awlen, clear beat_cnt, go ARB_W.
  - ARB_W: forward the granted requester's wvalid/wdata/wstrb/wlast and wid. Route wready only to the granted requester. On each wvalid&wready: beat_cnt+1.
    - On beat with wlast=1, go ARB_B.
    - If wlast≠(beat_cnt==len_q) on any accepted beat, set protocol_err=1. The state still follows wlast.
  - ARB_B: forward bvalid/bresp/bid to the granted requester and bready from it. On bvalid&bready: rr_ptr=(granted index+1) mod NUM_REQ, grant=0, go ARB_IDLE.
- Non-granted requesters always see awready=wready=bvalid=0.
- A requester that holds awvalid is guaranteed service within NUM_REQ transactions.
- Requesters issue AW before W. W presented before grant is simply stalled (wready=0).
- Holding a grant while the owner drops awvalid in ARB_AW is an AXI violation by the requester. Not required to be handled; grant is kept.
- beat_cnt is LEN_WIDTH bits and saturates at all-ones. A 16-beat burst with wlast on beat 16 is legal.
- A requester arriving in the same cycle as the B handshake is considered in the next ARB_IDLE cycle, not the same cycle.
- Reset mid-transaction abandons the downstream transaction: valids drop immediately, state=ARB_IDLE. This is only legal at system reset.
- Latency: first AW visible downstream 1 cycle after awvalid rises in ARB_IDLE. Zero added latency per W beat and on B.

Decomposition:
- Shared package (existing AXI3 package) holds axi3_wr_req_t, axi3_wr_resp_t, and a new arb_state_t enum (ARB_IDLE, ARB_AW, ARB_W, ARB_B).
- One natural sub-module: rr_pick. Combinational round-robin first-one-from-pointer selector, parameterised by NUM_REQ, returning a one-hot vector.

Test Plan:
- Single requester 0, awlen=7, 8 beats with wready always 1 → grant=01 one cycle after awvalid. Eight W beats pass unchanged. B routed to req0. Returns to ARB_IDLE; protocol_err=0.
- Both awvalid together from reset, rr_ptr=0 → req0 served first, req1 second. Then both request again → req0 served first again (rr_ptr=0 after req1). req1 never sees awready while req0 owns.
- req1 single beat (awlen=0) while req0 is mid-burst with wready toggling 1,0,1 → req1 stalls until req0's B completes. req0 beat_cnt advances only on handshake cycles.
- req0 asserts wlast on beat 3 of awlen=7 → protocol_err=1 and stays set. State moves to ARB_B; next transaction is granted normally.
- bvalid held 3 cycles while the granted requester's bready=0 → no state change. On bready=1, transition to ARB_IDLE and rr_ptr advances.
- Assert rst during ARB_W → same cycle m_req.wvalid=0, grant=0, protocol_err=0. After release, a new awvalid is granted normally.
